// File: rtl/zero_arb_if.sv
// Request/grant and result bus for the zero-detect arbiter.
// The master side drives requests and acknowledges; the slave side is the arbiter.
interface zero_arb_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             zero_out;
  logic             id_out;
  logic             valid_out;
  logic             out_ack;
  logic             busy;
  logic [7:0]       zcount;

  modport master (
    output req0, req1, data0, data1, out_ack,
    input  gnt0, gnt1, zero_out, id_out, valid_out, busy, zcount
  );

  modport slave (
    input  req0, req1, data0, data1, out_ack,
    output gnt0, gnt1, zero_out, id_out, valid_out, busy, zcount
  );
endinterface

// File: rtl/zero_arb.sv
// Two-requester round-robin arbiter feeding a registered zero detector.
// Defining ZERO_ARB_CNT_EN adds a saturating 8-bit count of zero results on zcount.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner's operand
// EVAL  | grant pulse is out; zero-detect the latched operand
// HOLD  | result valid, held until out_ack
module zero_arb #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  zero_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             win_q, win_d;
  logic             ptr_q, ptr_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             id_q, id_d;
  logic             busy_q, busy_d;

  logic any_req;
  logic pick;
  logic opnd_zero;
  logic take;

  // ptr_q names the requester favoured when both are asking.
  assign any_req   = bus.req0 | bus.req1;
  assign pick      = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
  assign opnd_zero = ~|opnd_q;
  assign take      = (state_q == IDLE) && any_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EVAL;
      EVAL:    state_d = HOLD;
      HOLD:    if (bus.out_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0_d  = take && !pick;
    gnt1_d  = take && pick;
    valid_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
    zero_d  = zero_q;
    id_d    = id_q;
    opnd_d  = opnd_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    if (take) begin
      opnd_d = pick ? bus.data1 : bus.data0;
      win_d  = pick;
      ptr_d  = ~pick;
    end
    if (state_q == EVAL) begin
      zero_d = opnd_zero;
      id_d   = win_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opnd_q  <= '0;
      win_q   <= 1'b0;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      id_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      opnd_q  <= opnd_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.valid_out = valid_q;
  assign bus.zero_out  = zero_q;
  assign bus.id_out    = id_q;
  assign bus.busy      = busy_q;

`ifdef ZERO_ARB_CNT_EN
  logic [7:0] zcnt_q, zcnt_d;

  // Counted on the EVAL->HOLD step so it lines up with valid_out rising.
  always_comb begin
    zcnt_d = zcnt_q;
    if ((state_q == EVAL) && opnd_zero && (zcnt_q != 8'hFF)) begin
      zcnt_d = zcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zcnt_q <= 8'd0;
    end else begin
      zcnt_q <= zcnt_d;
    end
  end

  assign bus.zcount = zcnt_q;
`else
  assign bus.zcount = 8'd0;
`endif

endmodule

// File: tb/tb_zero_arb.sv
// Scoreboard bench for zero_arb: expected results are queued as requests are driven
// and popped when valid_out rises. Build with ZERO_ARB_CNT_EN to exercise zcount.
module tb_zero_arb;
  localparam int W = 8;
`ifdef ZERO_ARB_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic id;
    logic zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  zero_arb_if #(.WIDTH(W)) bus ();
  zero_arb #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  exp_t sb[$];
  logic gsb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_ptr = 1'b0;
  int   exp_zc = 0;

  function automatic logic model_pick(input logic r0, input logic r1);
    return (r0 && r1) ? exp_ptr : r1;
  endfunction

  // Called at a negedge; returns at the negedge after valid_out has dropped.
  task automatic do_txn(input logic r0, input logic r1, input logic [W-1:0] d0,
                        input logic [W-1:0] d1, input int hold_cyc);
    logic w;
    exp_t e;
    bus.req0 = r0; bus.req1 = r1; bus.data0 = d0; bus.data1 = d1;
    w = model_pick(r0, r1);
    e.id = w;
    e.zero = ((w ? d1 : d0) == '0);
    sb.push_back(e);
    exp_ptr = ~w;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== ~w || bus.gnt1 !== w) begin
      errors++;
      $display("FAIL txn_gnt: gnt0=%b gnt1=%b expected gnt0=%b gnt1=%b", bus.gnt0, bus.gnt1, ~w, w);
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL txn_eval: valid=%b busy=%b expected valid=0 busy=1", bus.valid_out, bus.busy);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL txn_sb: scoreboard empty at result, expected one entry");
    end else begin
      e = sb.pop_front();
      if (CNT_EN && e.zero && exp_zc < 255) exp_zc++;
      if (bus.valid_out !== 1'b1 || bus.zero_out !== e.zero || bus.id_out !== e.id) begin
        errors++;
        $display("FAIL txn_result: valid=%b zero=%b id=%b expected valid=1 zero=%b id=%b",
                 bus.valid_out, bus.zero_out, bus.id_out, e.zero, e.id);
      end
      checks++;
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
        errors++;
        $display("FAIL txn_gnt_pulse: gnt0=%b gnt1=%b expected 0 0", bus.gnt0, bus.gnt1);
      end
      checks++;
      if (bus.zcount !== 8'(exp_zc)) begin
        errors++;
        $display("FAIL txn_zcount: got %0d expected %0d", bus.zcount, exp_zc);
      end
      for (int i = 0; i < hold_cyc; i++) begin
        @(negedge clk);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.zero_out !== e.zero || bus.id_out !== e.id || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL txn_hold: valid=%b zero=%b id=%b busy=%b expected 1 %b %b 1",
                   bus.valid_out, bus.zero_out, bus.id_out, bus.busy, e.zero, e.id);
        end
      end
    end
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL txn_ack: valid=%b busy=%b expected 0 0", bus.valid_out, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0; bus.out_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.valid_out, bus.zero_out, bus.id_out, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt0 gnt1 valid zero id busy = %b%b%b%b%b%b expected 000000",
               bus.gnt0, bus.gnt1, bus.valid_out, bus.zero_out, bus.id_out, bus.busy);
    end
    checks++;
    if (bus.zcount !== 8'd0) begin
      errors++;
      $display("FAIL reset_zcount: got %0d expected 0", bus.zcount);
    end
    rst_n = 1'b1;
    exp_ptr = 1'b0;
    exp_zc = 0;
    @(negedge clk);
  endtask

  task automatic test_ack_ignored();
    bus.out_ack = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: valid=%b busy=%b gnt0=%b gnt1=%b expected all 0",
               bus.valid_out, bus.busy, bus.gnt0, bus.gnt1);
    end
    bus.out_ack = 1'b0;
  endtask

  task automatic test_single();
    do_txn(1'b1, 1'b0, 8'h00, 8'hFF, 0);
    do_txn(1'b1, 1'b0, 8'h01, 8'h00, 1);
  endtask

  task automatic test_hold();
    do_txn(1'b0, 1'b1, 8'h11, 8'h80, 5);
    do_txn(1'b0, 1'b1, 8'h11, 8'h00, 2);
  endtask

  task automatic test_both();
    do_txn(1'b1, 1'b1, 8'h00, 8'h40, 0);
    do_txn(1'b1, 1'b1, 8'h00, 8'h40, 0);
    do_txn(1'b1, 1'b1, 8'h20, 8'h00, 1);
    do_txn(1'b1, 1'b0, 8'h20, 8'h00, 0);
    do_txn(1'b1, 1'b1, 8'h00, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    logic last_g;
    int   ngnt;
    last_g = 1'b0;
    ngnt = 0;
    for (int i = 0; i < 10; i++) begin
      gsb.push_back(exp_ptr);
      exp_ptr = ~exp_ptr;
    end
    bus.data0 = 8'h00; bus.data1 = 8'h05;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.out_ack = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) begin
        errors++;
        $display("FAIL b2b_exclusive: gnt0=1 gnt1=1 at cycle %0d expected at most one", i);
      end
      if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
        ngnt++;
        last_g = bus.gnt1;
        checks++;
        if (gsb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_grant: grant to %0d at cycle %0d, none expected", bus.gnt1, i);
        end else if (bus.gnt1 !== gsb[0]) begin
          errors++;
          $display("FAIL b2b_order: grant to %0d expected %0d (grant #%0d)", bus.gnt1, gsb[0], ngnt);
          void'(gsb.pop_front());
        end else begin
          void'(gsb.pop_front());
        end
      end
      if (bus.valid_out === 1'b1) begin
        checks++;
        if (bus.id_out !== last_g || bus.zero_out !== (last_g == 1'b0)) begin
          errors++;
          $display("FAIL b2b_result: id=%b zero=%b expected id=%b zero=%b",
                   bus.id_out, bus.zero_out, last_g, (last_g == 1'b0));
        end
        if (CNT_EN && last_g == 1'b0 && exp_zc < 255) exp_zc++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) @(negedge clk);
    bus.out_ack = 1'b0;
    checks++;
    if (gsb.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: %0d grants missing, busy=%b expected 0 missing busy=0", gsb.size(), bus.busy);
    end
    gsb.delete();
    checks++;
    if (bus.zcount !== 8'(exp_zc)) begin
      errors++;
      $display("FAIL b2b_zcount: got %0d expected %0d", bus.zcount, exp_zc);
    end
  endtask

  task automatic test_reset_hold();
    bus.req0 = 1'b1; bus.req1 = 1'b0; bus.data0 = 8'h00;
    exp_ptr = ~model_pick(1'b1, 1'b0);
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_hold: valid=%b expected 1", bus.valid_out);
    end
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.zcount !== 8'd0) begin
      errors++;
      $display("FAIL rst_hold: valid=%b busy=%b zcount=%0d expected 0 0 0",
               bus.valid_out, bus.busy, bus.zcount);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_ignored: gnt0=%b gnt1=%b busy=%b expected 0 0 0", bus.gnt0, bus.gnt1, bus.busy);
    end
    rst_n = 1'b1;
    exp_ptr = 1'b0;
    exp_zc = 0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_grant: gnt0=%b gnt1=%b expected 1 0", bus.gnt0, bus.gnt1);
    end
    exp_ptr = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    if (CNT_EN) exp_zc = 1;
    checks++;
    if (bus.valid_out !== 1'b1 || bus.id_out !== 1'b0 || bus.zero_out !== 1'b1 || bus.zcount !== 8'(exp_zc)) begin
      errors++;
      $display("FAIL rst_first_result: valid=%b id=%b zero=%b zcount=%0d expected 1 0 1 %0d",
               bus.valid_out, bus.id_out, bus.zero_out, bus.zcount, exp_zc);
    end
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
  endtask

  task automatic test_zcount_sat();
    for (int i = 0; i < 300; i++) begin
      do_txn((i % 2) == 0, (i % 2) == 1, 8'h00, 8'h00, 0);
    end
    do_txn(1'b1, 1'b0, 8'h3C, 8'h00, 0);
    checks++;
    if (bus.zcount !== (CNT_EN ? 8'd255 : 8'd0)) begin
      errors++;
      $display("FAIL zcount_sat: got %0d expected %0d", bus.zcount, CNT_EN ? 255 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ack_ignored();
    test_single();
    test_hold();
    test_both();
    test_back_to_back();
    test_reset_hold();
    test_zcount_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zero_arb.md
ZERO_ARB -- requirements
Module: zero_arb

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req0, req1  input  1  request from requester 0 / 1.
REQ-005 SHALL have ports: data0, data1  input  WIDTH  operand for requester 0 / 1, held stable while its req is high.
REQ-006 SHALL have ports: gnt0, gnt1  output  1  one-cycle grant pulse; the operand is captured in that cycle.
REQ-007 SHALL have port: zero_out  output  1  result, 1 when the captured operand equals 0.
REQ-008 SHALL have port: id_out  output  1  index of the requester that owns the result.
REQ-009 SHALL have port: valid_out  output  1  result valid; held until acknowledged.
REQ-010 SHALL have port: out_ack  input  1  consumer acknowledge; sampled only while valid_out=1.
REQ-011 SHALL have port: busy  output  1  high in every state other than IDLE.
REQ-012 SHALL have port: zcount  output  8  count of zero results (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, EVAL, HOLD; all outputs registered.
REQ-014 IDLE: if req0|req1 is sampled at edge k, SHALL go to EVAL, assert the winner's gnt in cycle k+1, and latch the winner's data and id at edge k.
REQ-015 With a single request, that requester SHALL win.
REQ-016 With both requesting, the requester not granted last SHALL win; pointer reset value: requester 0 wins first.
REQ-017 The round-robin pointer SHALL update only on a grant.
REQ-018 EVAL: SHALL evaluate all WIDTH bits of the latched operand, go to HOLD, and drive valid_out=1, zero_out, id_out from cycle k+2 (two-cycle latency from req sample to valid).
REQ-019 HOLD: zero_out and id_out SHALL hold stable while valid_out=1; out_ack sampled high SHALL return the FSM to IDLE with valid_out=0 in the next cycle.
REQ-020 New requests SHALL NOT be arbitrated in EVAL or HOLD; the earliest next grant is 2 cycles after out_ack is sampled.
REQ-021 A requester SHALL drop req in the cycle after its gnt; a req still high then counts as a new request.
REQ-022 gnt0 and gnt1 SHALL never be high together; each SHALL be high for exactly 1 cycle per transaction.
REQ-023 out_ack while valid_out=0 SHALL be ignored.

Reset
REQ-024 rst_n low at a rising edge SHALL force IDLE, gnt0=gnt1=0, valid_out=0, zero_out=0, id_out=0, busy=0, zcount=0, and pointer to favour requester 0.
REQ-025 Reset in EVAL or HOLD SHALL discard the in-flight result with no grant or valid afterward; a req sampled during reset SHALL be ignored.

Configuration
REQ-026 Macro ZERO_ARB_CNT_EN defined: zcount SHALL increment by 1 on each IDLE->...->HOLD entry with zero result, saturating at 255.
REQ-027 ZERO_ARB_CNT_EN undefined: zcount SHALL be constant 0 with no counter logic; all other behaviour SHALL be identical.

Verification
REQ-028 req0=1, data0=8'h00 at cycle 0 -> gnt0=1 in cycle 1; valid_out=1, zero_out=1, id_out=0 in cycle 2.
REQ-029 req1=1, data1=8'h80, out_ack held 0 for 5 cycles -> valid_out=1, zero_out=0, id_out=1 stable throughout; out_ack=1 -> valid_out=0 next cycle.
REQ-030 req0 and req1 held high continuously with immediate acks -> grant order 0,1,0,1 and never both gnt high.
REQ-031 rst_n=0 during HOLD -> next cycle valid_out=0, busy=0, zcount=0; first grant after reset goes to requester 0.
REQ-032 With ZERO_ARB_CNT_EN, 300 zero-operand transactions -> zcount=255; a nonzero operand leaves it unchanged; without the macro zcount=0.
